// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP,
        DRAIN
    } arb_state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 200000;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, wrapping.
module i2c_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int cand;

    // Scan from lowest to highest priority so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin accept,
// issue one command, wait for done or timeout, route the result back.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_op,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_dout,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              m_newd,
    output logic              m_op,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_din,
    input  logic [7:0]        m_dout,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_ack_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [IW-1:0] last_q, last_d;
    logic          m_op_q, m_op_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic [7:0]    m_din_q, m_din_d;
    logic [7:0]    dout_q, dout_d;
    logic          err_q, err_d;
    logic          to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          grant;

    logic [6:0] addr_arr [NREQ];
    logic [7:0] din_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*7 +: 7];
        assign din_arr[gi]  = req_din[gi*8 +: 8];
    end

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // Gated by rst so no accept pulse escapes while reset is held.
    assign grant = rst && (state_q == IDLE) && !m_busy && pick_found;

    assign req_ready   = grant ? (NREQ'(1) << pick_idx) : '0;
    assign rsp_valid   = (state_q == RESP) ? (NREQ'(1) << cur_q) : '0;
    assign m_newd      = (state_q == ISSUE);
    assign m_op        = m_op_q;
    assign m_addr      = m_addr_q;
    assign m_din       = m_din_q;
    assign rsp_dout    = dout_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        m_op_d   = m_op_q;
        m_addr_d = m_addr_q;
        m_din_d  = m_din_q;
        dout_d   = dout_q;
        err_d    = err_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    cur_d    = pick_idx;
                    last_d   = pick_idx;
                    m_op_d   = req_op[pick_idx];
                    m_addr_d = addr_arr[pick_idx];
                    m_din_d  = din_arr[pick_idx];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle still counts as a real completion.
                if (m_done) begin
                    dout_d  = m_dout;
                    err_d   = m_ack_err;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    dout_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = to_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!m_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            m_op_q   <= OP_WRITE;
            m_addr_q <= '0;
            m_din_q  <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            m_op_q   <= m_op_d;
            m_addr_q <= m_addr_d;
            m_din_q  <= m_din_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one I2C master between NREQ independent requesters. It accepts per-requester transaction requests, serialises them onto the master's newd/op/addr/din command interface, and waits for the master's done. It then routes dout and error status back to the requester that issued the transaction. It sits between client logic (register pollers, sensor readers, config loaders) and the I2C top, and owns that top's command inputs exclusively.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 200000: max clk cycles from newd to done; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  bit i = requester i has a pending transaction; held until req_ready[i].
- req_ready  out  NREQ  one-hot single-cycle accept pulse.
- req_op  in  NREQ  per-requester op: 1 = read, 0 = write.
- req_addr  in  7*NREQ  slice i = 7-bit slave address of requester i.
- req_din  in  8*NREQ  slice i = write data of requester i.
- rsp_valid  out  NREQ  one-hot single-cycle completion pulse.
- rsp_dout  out  8  read data; valid with rsp_valid.
- rsp_err  out  1  ack error or timeout; valid with rsp_valid.
- rsp_timeout  out  1  completion was caused by timeout; valid with rsp_valid.
- m_newd  out  1  one-cycle start pulse to the I2C master.
- m_op, m_addr[6:0], m_din[7:0]  out  command fields, registered, stable from issue until completion.
- m_dout  in  8  master read data.
- m_busy  in  1  master busy.
- m_done  in  1  master done pulse.
- m_ack_err  in  1  master/slave ack error, sampled with m_done.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: drive m_newd.
  - WAIT_DONE: wait for completion.
  - RESP: return the result.
  - DRAIN: wait for the master to go idle after a timeout.
- IDLE: if any req_valid and m_busy==0:
  - pick the winner by round-robin starting at last_grant+1 (mod NREQ);
  - latch op/addr/din into m_* registers and the winner index into cur;
  - pulse req_ready[cur];
  - set last_grant=cur; go to ISSUE.
- ISSUE: m_newd=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - m_done=1: capture m_dout into rsp_dout and m_ack_err into rsp_err; rsp_timeout=0; go to RESP.
  - Else, if TIMEOUT!=0 and the counter reaches TIMEOUT-1: rsp_err=1, rsp_timeout=1, rsp_dout=0; go to RESP.
  - m_done and timeout in the same cycle: done wins.
- RESP: pulse rsp_valid[cur] for one cycle. Go to DRAIN if the completion was a timeout, else go to IDLE.
- DRAIN: stay until m_busy==0; then IDLE.
- m_done seen outside WAIT_DONE is ignored.
- A requester dropping req_valid before its req_ready is simply not served. No partial state remains.
- A requester may reassert req_valid in the cycle after its rsp_valid. Other pending requesters still take priority per round-robin.

## Timing
- Reset (rst==0 at an edge):
  - state=IDLE, last_grant=NREQ-1 (requester 0 first);
  - req_ready=0, rsp_valid=0, rsp_dout=0, rsp_err=0, rsp_timeout=0;
  - m_newd=0, m_op=0, m_addr=0, m_din=0; timeout counter=0.
- Reset mid-transaction aborts without a response. The master is reset by the same system reset.
- Accept at cycle T (req_ready high); m_newd high at T+1.
- m_done at cycle D gives rsp_valid at D+1; the next accept is possible at D+2 at the earliest.
- Minimum gap between consecutive m_newd pulses: 3 cycles plus the master's transaction time.
- m_op/m_addr/m_din are constant from T+1 through the RESP cycle.
- The timeout counter is log2(TIMEOUT)+1 bits, saturating, and counts only in WAIT_DONE.

## Structure
- Package i2c_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_DONE, RESP, DRAIN);
  - op encoding constants OP_WRITE=0, OP_READ=1;
  - default NREQ and TIMEOUT.
- Sub-module i2c_rr_pick: combinational round-robin selector. Inputs: request vector and last_grant. Outputs: found and index. Instantiated once.
- Top FSM, field muxing, and timeout counter live in i2c_req_arbiter. The I2C top is instantiated beside it in the bench, not inside it.

## Test plan
- Single request: requester 2 write addr 0x50, din 0xA5 → req_ready[2] one cycle; m_newd one cycle later with m_addr=0x50, m_din=0xA5, m_op=0; after m_done, rsp_valid[2] with rsp_err=0.
- All four requesters valid from reset, held → grant order 0,1,2,3,0 with exactly one m_newd per transaction and no overlap with m_busy.
- Read of a responding slave at 0x50 returning 0x3C → rsp_dout=0x3C on rsp_valid.
- Address 0x7F with no slave (ack error) → rsp_err=1, rsp_timeout=0; the next request proceeds normally.
- TIMEOUT=50, m_done forced low → rsp_valid 50 cycles after ISSUE with rsp_err=1, rsp_timeout=1; FSM holds in DRAIN until m_busy falls.
- rst low while in WAIT_DONE → every output at its reset value on the next cycle; no rsp_valid for the aborted request; requester 0 is served first after release.
